// File: rtl/bp_fe_pkg.sv
// Shared types for the front-end BHT scheduler.
// The update record width follows the BHT index width, so it is built by a macro.
package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_idle,
    e_active,
    e_force
  } bp_fe_bht_sched_state_e;

endpackage

`define BP_FE_BHT_UPD_S(idx_width) \
  typedef struct packed { \
    logic [idx_width-1:0] idx; \
    logic                 correct; \
  } bp_fe_bht_upd_s

// File: rtl/bp_fe_bht_upd_fifo.sv
// Small circular FIFO with valid/ready enqueue, yumi dequeue, clear and a registered count.
module bp_fe_bht_upd_fifo #(
  parameter int unsigned width_p = 10,
  parameter int unsigned els_p   = 4,
  localparam int unsigned ptr_width_lp = $clog2(els_p),
  localparam int unsigned cnt_width_lp = ptr_width_lp + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    clr_i,
  input  logic                    v_i,
  input  logic [width_p-1:0]      data_i,
  output logic                    ready_o,
  input  logic                    yumi_i,
  output logic                    v_o,
  output logic [width_p-1:0]      data_o,
  output logic                    full_o,
  output logic [cnt_width_lp-1:0] cnt_o
);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [ptr_width_lp:0]   rptr_q, wptr_q;
  logic [cnt_width_lp-1:0] cnt_q;
  logic [width_p-1:0]      mem [els_p];
  logic                    empty, full, enq, deq;

  always_comb begin
    empty   = (rptr_q == wptr_q);
    full    = (rptr_q[ptr_width_lp] != wptr_q[ptr_width_lp])
            & (rptr_q[ptr_width_lp-1:0] == wptr_q[ptr_width_lp-1:0]);
    enq     = v_i & ~full & ~clr_i;
    deq     = yumi_i & ~empty & ~clr_i;
    ready_o = ~full;
    full_o  = full;
    v_o     = ~empty;
    data_o  = mem[rptr_q[ptr_width_lp-1:0]];
    cnt_o   = cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clr_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq) wptr_q <= wptr_q + (ptr_width_lp + 1)'(1);
      if (deq) rptr_q <= rptr_q + (ptr_width_lp + 1)'(1);
      cnt_q <= cnt_q + cnt_width_lp'(enq) - cnt_width_lp'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr_q[ptr_width_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_fe_bht_sched.sv
// Arbitrates BHT lookups and queued direction updates onto one read and one write port,
// deferring a write that collides with the same-cycle lookup for a bounded number of cycles.
module bp_fe_bht_sched
  import bp_fe_pkg::*;
#(
  parameter int unsigned bht_idx_width_p = 9,
  parameter int unsigned upd_fifo_els_p  = 4,
  parameter int unsigned max_defer_p     = 3,
  localparam int unsigned cnt_width_lp   = $clog2(upd_fifo_els_p) + 1,
  localparam int unsigned defer_width_lp = $clog2(max_defer_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       lookup_v_i,
  input  logic [bht_idx_width_p-1:0] lookup_idx_i,
  output logic                       lookup_ready_o,
  output logic                       predict_v_o,
  output logic                       predict_o,
  input  logic                       upd_v_i,
  input  logic [bht_idx_width_p-1:0] upd_idx_i,
  input  logic                       upd_correct_i,
  output logic                       upd_ready_o,
  input  logic                       flush_i,
  output logic                       bht_r_v_o,
  output logic [bht_idx_width_p-1:0] bht_idx_r_o,
  output logic                       bht_w_v_o,
  output logic [bht_idx_width_p-1:0] bht_idx_w_o,
  output logic                       bht_correct_o,
  input  logic                       bht_predict_i,
  output logic [cnt_width_lp-1:0]    fifo_cnt_o
);

  `BP_FE_BHT_UPD_S(bht_idx_width_p);

  bp_fe_bht_upd_s          enq_data, head;
  bp_fe_bht_sched_state_e  state_q, state_n;
  logic [defer_width_lp-1:0] defer_q, defer_n;
  logic [cnt_width_lp-1:0] cnt, cnt_n;
  logic fifo_v, fifo_full, fifo_ready;
  logic hazard, full_hazard, in_force, lookup_ready, read, write, defer, enq_v, upd_ready;
  logic predict_v_q;

  assign enq_data = '{idx: upd_idx_i, correct: upd_correct_i};

  bp_fe_bht_upd_fifo #(
    .width_p($bits(bp_fe_bht_upd_s)),
    .els_p  (upd_fifo_els_p)
  ) upd_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clr_i    (flush_i),
    .v_i      (enq_v),
    .data_i   (enq_data),
    .ready_o  (fifo_ready),
    .yumi_i   (write),
    .v_o      (fifo_v),
    .data_o   (head),
    .full_o   (fifo_full),
    .cnt_o    (cnt)
  );

  always_comb begin
    in_force     = (state_q == e_force);
    hazard       = fifo_v & lookup_v_i & (head.idx == lookup_idx_i);
    full_hazard  = fifo_full & hazard;
    lookup_ready = reset_n_i & ~in_force & ~full_hazard;
    read         = lookup_v_i & lookup_ready;
    write        = reset_n_i & fifo_v & ~flush_i & (in_force | full_hazard | ~hazard);
    defer        = reset_n_i & fifo_v & ~flush_i & ~write;
    upd_ready    = reset_n_i & fifo_ready & ~flush_i;
    enq_v        = upd_v_i & upd_ready;
    cnt_n        = cnt + cnt_width_lp'(enq_v) - cnt_width_lp'(write);

    defer_n = defer_q;
    if (flush_i || write) defer_n = '0;
    else if (defer)       defer_n = defer_q + defer_width_lp'(1);

    // Force once the head has waited its limit, or if a deferral leaves the FIFO full.
    state_n = e_active;
    if (flush_i || cnt_n == '0) begin
      state_n = e_idle;
    end else if (defer && (defer_n == defer_width_lp'(max_defer_p)
                           || cnt_n == cnt_width_lp'(upd_fifo_els_p))) begin
      state_n = e_force;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= e_idle;
      defer_q     <= '0;
      predict_v_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      defer_q     <= defer_n;
      predict_v_q <= read;
    end
  end

  always_comb begin
    lookup_ready_o = lookup_ready;
    upd_ready_o    = upd_ready;
    bht_r_v_o      = read;
    bht_idx_r_o    = read ? lookup_idx_i : '0;
    bht_w_v_o      = write;
    bht_idx_w_o    = write ? head.idx : '0;
    bht_correct_o  = write & head.correct;
    predict_v_o    = reset_n_i & predict_v_q;
    predict_o      = reset_n_i & predict_v_q & bht_predict_i;
    fifo_cnt_o     = reset_n_i ? cnt : '0;
  end

endmodule
